// File: rtl/bpu_update_scheduler.sv
// bpu_update_scheduler: merges the two commit lanes, in program order, into a
// small update queue for the gshare PHT and issues one update per cycle. It also
// sequences the full-table initialisation sweep after reset or a clear request.
//
// state | meaning
// SWEEP | writing the reset value to every PHT index; no updates issued
// RUN   | accepting commits, issuing one queued update per cycle
// DRAIN | clear requested; commits blocked, queue emptied before the next sweep
module bpu_update_scheduler #(
    parameter int PC_WIDTH       = 32,
    parameter int PHT_DEPTH_EXP2 = 10,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      commit0_valid_i,
    input  logic [PC_WIDTH:0]         commit0_info_i,
    input  logic                      commit1_valid_i,
    input  logic [PC_WIDTH:0]         commit1_info_i,
    output logic                      commit_ready_o,
    input  logic                      clear_i,
    output logic                      update_valid_o,
    output logic [PC_WIDTH:0]         update_instr_info_o,
    output logic                      sweep_valid_o,
    output logic [PHT_DEPTH_EXP2-1:0] sweep_index_o,
    output logic                      busy_o
);
    localparam int IW = PC_WIDTH + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    // Ready means at least two free slots, so a dual-lane push always fits.
    localparam logic [CW-1:0] READY_MAX = CW'(QUEUE_DEPTH - 2);

    typedef enum logic [1:0] {SWEEP, RUN, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [PHT_DEPTH_EXP2-1:0] sweep_idx, sweep_idx_nxt;
    logic [IW-1:0]             mem [QUEUE_DEPTH];
    logic [PW-1:0]             rd_ptr, wr_ptr, wr_ptr_p1;
    logic [CW-1:0]             count;
    logic                      push0, push1, pop;
    logic [1:0]                n_push;

    // Handshake, issue and sweep outputs decode registered state only.
    always_comb begin
        commit_ready_o      = (state == RUN) && (count <= READY_MAX);
        pop                 = (count != '0) && (state != SWEEP);
        update_valid_o      = pop;
        update_instr_info_o = (count != '0) ? mem[rd_ptr] : '0;
        sweep_valid_o       = (state == SWEEP);
        sweep_index_o       = sweep_idx;
        busy_o              = (state != RUN);
        push0               = commit_ready_o && commit0_valid_i;
        push1               = commit_ready_o && commit1_valid_i;
        n_push              = {1'b0, push0} + {1'b0, push1};
        wr_ptr_p1           = wr_ptr + PW'(1);
    end

    // Next-state and sweep index sequencing.
    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        case (state)
            SWEEP: begin
                if (clear_i) begin
                    sweep_idx_nxt = '0;
                end else if (&sweep_idx) begin
                    state_nxt     = RUN;
                    sweep_idx_nxt = '0;
                end else begin
                    sweep_idx_nxt = sweep_idx + 1'b1;
                end
            end
            RUN: begin
                if (clear_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (count == '0) begin
                    state_nxt     = SWEEP;
                    sweep_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt     = SWEEP;
                sweep_idx_nxt = '0;
            end
        endcase
    end

    // State register; reset starts a fresh sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // Queue pointers and occupancy; reset discards anything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Queue storage: lane0 takes the first free slot, lane1 the next one.
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= commit0_info_i;
        if (push1) mem[push0 ? wr_ptr_p1 : wr_ptr] <= commit1_info_i;
    end

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Testbench for bpu_update_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_bpu_update_scheduler;
    localparam int PCW = 32;
    localparam int EXP = 4;
    localparam int QD  = 4;
    localparam int NS  = 1 << EXP;
    localparam int M_SWEEP = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic           clk, rst;
    logic           c0v, c1v, clr;
    logic [PCW:0]   c0i, c1i;
    logic           commit_ready_o, update_valid_o, sweep_valid_o, busy_o;
    logic [PCW:0]   update_instr_info_o;
    logic [EXP-1:0] sweep_index_o;

    int total = 0;
    int bad   = 0;

    bpu_update_scheduler #(.PC_WIDTH(PCW), .PHT_DEPTH_EXP2(EXP), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .commit0_valid_i(c0v), .commit0_info_i(c0i),
        .commit1_valid_i(c1v), .commit1_info_i(c1i),
        .commit_ready_o(commit_ready_o), .clear_i(clr),
        .update_valid_o(update_valid_o), .update_instr_info_o(update_instr_info_o),
        .sweep_valid_o(sweep_valid_o), .sweep_index_o(sweep_index_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0v = 0; c1v = 0; clr = 0; c0i = '0; c1i = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        total++; if (commit_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", commit_ready_o); end
        total++; if (update_valid_o !== 1'b0) begin bad++; $display("FAIL rst_upd_valid got=%0b exp=0", update_valid_o); end
        total++; if (update_instr_info_o !== '0) begin bad++; $display("FAIL rst_upd_info got=%0h exp=0", update_instr_info_o); end
        total++; if (sweep_valid_o !== 1'b1) begin bad++; $display("FAIL rst_sweep_valid got=%0b exp=1", sweep_valid_o); end
        total++; if (sweep_index_o !== '0) begin bad++; $display("FAIL rst_sweep_idx got=%0d exp=0", sweep_index_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0b exp=1", busy_o); end
        tick();
        rst = 0;
        for (int i = 0; i < NS; i++) begin
            total++; if (sweep_index_o !== EXP'(i) || sweep_valid_o !== 1'b1 || busy_o !== 1'b1)
                begin bad++; $display("FAIL sweep_step idx=%0d sv=%0b busy=%0b exp_idx=%0d", sweep_index_o, sweep_valid_o, busy_o, i); end
            total++; if (commit_ready_o !== 1'b0 || update_valid_o !== 1'b0)
                begin bad++; $display("FAIL sweep_quiet ready=%0b upd=%0b exp=0/0", commit_ready_o, update_valid_o); end
            tick();
        end
        total++; if (commit_ready_o !== 1'b1 || busy_o !== 1'b0 || sweep_valid_o !== 1'b0)
            begin bad++; $display("FAIL run_entry ready=%0b busy=%0b sv=%0b exp=1/0/0", commit_ready_o, busy_o, sweep_valid_o); end
    endtask

    task automatic test_pair();
        c0v = 1; c0i = {32'h100, 1'b1};
        c1v = 1; c1i = {32'h104, 1'b0};
        total++; if (commit_ready_o !== 1'b1) begin bad++; $display("FAIL pair_ready got=%0b exp=1", commit_ready_o); end
        tick();
        idle_inputs();
        total++; if (update_valid_o !== 1'b1 || update_instr_info_o !== {32'h100, 1'b1})
            begin bad++; $display("FAIL pair_first v=%0b got=%0h exp=%0h", update_valid_o, update_instr_info_o, {32'h100, 1'b1}); end
        tick();
        total++; if (update_valid_o !== 1'b1 || update_instr_info_o !== {32'h104, 1'b0})
            begin bad++; $display("FAIL pair_second v=%0b got=%0h exp=%0h", update_valid_o, update_instr_info_o, {32'h104, 1'b0}); end
        tick();
        total++; if (update_valid_o !== 1'b0 || update_instr_info_o !== '0)
            begin bad++; $display("FAIL pair_empty v=%0b got=%0h exp=0", update_valid_o, update_instr_info_o); end
    endtask

    task automatic test_fill();
        logic [PCW:0]  exp_e[$];
        logic [PCW:0]  got[$];
        logic [31:0]   pc;
        logic          exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                pc = 32'h200 + 32'(k * 8);
                c0v = 1; c0i = {pc, k[0]};
                c1v = 1; c1i = {pc + 32'h4, ~k[0]};
                total++; if (commit_ready_o !== exp_rdy[k])
                    begin bad++; $display("FAIL fill_ready cyc=%0d got=%0b exp=%0b", k, commit_ready_o, exp_rdy[k]); end
                if (exp_rdy[k]) begin exp_e.push_back(c0i); exp_e.push_back(c1i); end
            end else begin
                idle_inputs();
            end
            if (update_valid_o) got.push_back(update_instr_info_o);
            tick();
        end
        total++; if (got.size() != exp_e.size())
            begin bad++; $display("FAIL fill_count got=%0d exp=%0d", got.size(), exp_e.size()); end
        for (int i = 0; i < exp_e.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_e[i])
                begin bad++; $display("FAIL fill_order idx=%0d got=%0h exp=%0h", i, got[i], exp_e[i]); end
        end
    endtask

    task automatic test_clear_drain();
        logic [PCW:0] e[4];
        logic [PCW:0] got[$];
        bit           seen_sweep = 0;
        for (int i = 0; i < 4; i++) e[i] = {32'h300 + 32'(i * 4), i[0]};
        c0v = 1; c0i = e[0]; c1v = 1; c1i = e[1];
        tick();
        c0i = e[2]; c1i = e[3];
        tick();
        idle_inputs();
        clr = 1;
        if (update_valid_o) got.push_back(update_instr_info_o);
        tick();
        clr = 0;
        for (int n = 0; n < 20; n++) begin
            if (sweep_valid_o) begin seen_sweep = 1; break; end
            total++; if (commit_ready_o !== 1'b0 || busy_o !== 1'b1)
                begin bad++; $display("FAIL drain_ready ready=%0b busy=%0b exp=0/1", commit_ready_o, busy_o); end
            if (update_valid_o) got.push_back(update_instr_info_o);
            tick();
        end
        total++; if (!seen_sweep) begin bad++; $display("FAIL drain_timeout got=no_sweep exp=sweep"); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL drain_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== e[i+1])
                begin bad++; $display("FAIL drain_order idx=%0d got=%0h exp=%0h", i, got[i], e[i+1]); end
        end
        for (int i = 0; i < NS; i++) begin
            total++; if (sweep_index_o !== EXP'(i) || sweep_valid_o !== 1'b1 || update_valid_o !== 1'b0)
                begin bad++; $display("FAIL drain_sweep idx=%0d sv=%0b upd=%0b exp_idx=%0d", sweep_index_o, sweep_valid_o, update_valid_o, i); end
            tick();
        end
        total++; if (commit_ready_o !== 1'b1 || busy_o !== 1'b0)
            begin bad++; $display("FAIL drain_run ready=%0b busy=%0b exp=1/0", commit_ready_o, busy_o); end
    endtask

    task automatic test_clear_sweep();
        do_reset();
        repeat (9) tick();
        total++; if (sweep_index_o !== EXP'(9)) begin bad++; $display("FAIL csw_idx9 got=%0d exp=9", sweep_index_o); end
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < NS; i++) begin
            total++; if (sweep_index_o !== EXP'(i) || sweep_valid_o !== 1'b1)
                begin bad++; $display("FAIL csw_step idx=%0d sv=%0b exp_idx=%0d", sweep_index_o, sweep_valid_o, i); end
            tick();
        end
        total++; if (commit_ready_o !== 1'b1 || busy_o !== 1'b0)
            begin bad++; $display("FAIL csw_run ready=%0b busy=%0b exp=1/0", commit_ready_o, busy_o); end
    endtask

    task automatic test_reset_drain();
        logic [PCW:0] e[4];
        for (int i = 0; i < 4; i++) e[i] = {32'h400 + 32'(i * 4), ~i[0]};
        c0v = 1; c0i = e[0]; c1v = 1; c1i = e[1];
        tick();
        c0i = e[2]; c1i = e[3]; clr = 1;
        total++; if (commit_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ready got=%0b exp=1", commit_ready_o); end
        tick();
        idle_inputs();
        tick();
        total++; if (update_valid_o !== 1'b1 || update_instr_info_o !== e[2])
            begin bad++; $display("FAIL rd_head v=%0b got=%0h exp=%0h", update_valid_o, update_instr_info_o, e[2]); end
        #2;
        rst = 1;
        #1;
        total++; if (commit_ready_o !== 1'b0 || update_valid_o !== 1'b0 || update_instr_info_o !== '0)
            begin bad++; $display("FAIL rd_async_q ready=%0b upd=%0b info=%0h exp=0/0/0", commit_ready_o, update_valid_o, update_instr_info_o); end
        total++; if (sweep_valid_o !== 1'b1 || sweep_index_o !== '0 || busy_o !== 1'b1)
            begin bad++; $display("FAIL rd_async_s sv=%0b idx=%0d busy=%0b exp=1/0/1", sweep_valid_o, sweep_index_o, busy_o); end
        tick();
        tick();
        rst = 0;
        for (int n = 0; n < NS + 8; n++) begin
            total++; if (update_valid_o !== 1'b0)
                begin bad++; $display("FAIL rd_stale cyc=%0d got=%0b exp=0", n, update_valid_o); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [PCW:0] q[$];
        int           mode, idx, sz;
        bit           e_rdy, e_upd;
        logic [PCW:0] e_info;
        do_reset();
        mode = M_SWEEP; idx = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            c0v = ($urandom_range(0, 3) != 0);
            c1v = ($urandom_range(0, 3) != 0);
            c0i = {$urandom, 1'($urandom_range(0, 1))};
            c1i = {$urandom, 1'($urandom_range(0, 1))};
            clr = ($urandom_range(0, 39) == 0);
            sz     = q.size();
            e_rdy  = (mode == M_RUN) && (sz <= QD - 2);
            e_upd  = (mode != M_SWEEP) && (sz != 0);
            e_info = (sz != 0) ? q[0] : '0;
            total++; if (commit_ready_o !== e_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, commit_ready_o, e_rdy); end
            total++; if (update_valid_o !== e_upd) begin bad++; $display("FAIL rnd_upd cyc=%0d got=%0b exp=%0b", cyc, update_valid_o, e_upd); end
            total++; if (update_instr_info_o !== e_info) begin bad++; $display("FAIL rnd_info cyc=%0d got=%0h exp=%0h", cyc, update_instr_info_o, e_info); end
            total++; if (sweep_valid_o !== (mode == M_SWEEP)) begin bad++; $display("FAIL rnd_sv cyc=%0d got=%0b exp=%0b", cyc, sweep_valid_o, mode == M_SWEEP); end
            total++; if (sweep_index_o !== EXP'(idx)) begin bad++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, sweep_index_o, idx); end
            total++; if (busy_o !== (mode != M_RUN)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, mode != M_RUN); end
            total++; if (sweep_valid_o === 1'b1 && update_valid_o === 1'b1) begin bad++; $display("FAIL rnd_excl cyc=%0d got=both exp=one", cyc); end
            if (e_upd) void'(q.pop_front());
            if (e_rdy && c0v) q.push_back(c0i);
            if (e_rdy && c1v) q.push_back(c1i);
            case (mode)
                M_SWEEP: if (clr) idx = 0;
                         else if (idx == NS - 1) begin mode = M_RUN; idx = 0; end
                         else idx++;
                M_RUN:   if (clr) mode = M_DRAIN;
                default: if (sz == 0) begin mode = M_SWEEP; idx = 0; end
            endcase
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_pair();
        test_fill();
        test_clear_drain();
        test_clear_sweep();
        test_reset_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
